ones_frame_accumulator: RTL
===========================

// Module: ones_frame_accumulator
// PURPOSE
//  Downstream of the per-byte ones-count stage. Sums the 4-bit per-byte ones counts
//  over a frame of up to FRAME_LEN bytes and presents the frame total, the byte count
//  and a balanced flag (ones == zeros) on a valid/ready output. Supplies backpressure
//  upstream through cnt_ready.
// PARAMETERS
//  FRAME_LEN  16  bytes per full frame; legal range 1..255
//  SUM_W      12  width of sum_total; must satisfy 2**SUM_W > 8*FRAME_LEN
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high reset
//  cnt_valid   in   1      cnt_in and frame_last are valid this cycle
//  cnt_in      in   4      ones count of one byte; legal values 0..8
//  frame_last  in   1      with an accepted beat: close the frame early
//  cnt_ready   out  1      block can accept a beat this cycle
//  sum_valid   out  1      frame result is held on the sum_* outputs
//  sum_ready   in   1      downstream consumes the result
//  sum_total   out  SUM_W  total ones in the frame
//  sum_bytes   out  8      bytes in the frame (1..FRAME_LEN)
//  balanced    out  1      sum_total == 4*sum_bytes
//  err_range   out  1      sticky flag: a beat arrived with cnt_in > 8
// BEHAVIOUR
//  - Reset: state=ACCUM, acc=0, byte_cnt=0, sum_valid=0, sum_total=0, sum_bytes=0,
//    balanced=0, err_range=0. Any partial frame is discarded. Reset overrides all else.
//  - Accept: a beat is accepted on a clock edge where cnt_valid && cnt_ready.
//  - cnt_in > 8 is treated as 8 (saturated) and sets err_range. err_range clears
//    only on reset.
//  - State ACCUM: cnt_ready=1. On accept:
//      acc += cnt_sat; byte_cnt += 1.
//      The frame closes when byte_cnt+1 == FRAME_LEN or frame_last=1.
//  - Frame close (registered, same edge as the closing accept):
//      sum_total <= acc + cnt_sat; sum_bytes <= byte_cnt + 1;
//      balanced <= (sum_total == 4*sum_bytes); sum_valid <= 1;
//      acc <= 0; byte_cnt <= 0; state -> HOLD.
//    Latency: the result is visible the cycle after the closing beat is accepted.
//  - State HOLD: cnt_ready = sum_ready (combinational).
//      sum_* and balanced stay stable while sum_valid && !sum_ready.
//      When sum_ready=1: sum_valid <= 0; state -> ACCUM.
//      If a beat is accepted in that same cycle, it is the first beat of the next frame
//      (acc = cnt_sat, byte_cnt = 1). If that beat also closes the frame
//      (FRAME_LEN=1 or frame_last=1), sum_valid stays 1 with the new result and the
//      state remains HOLD.
//  - No beat is lost or duplicated: every accepted beat lands in exactly one frame.
//  - Width: acc and sum_total are SUM_W bits and never wrap under legal parameters.
//  - cnt_valid=0 cycles inside a frame are idle gaps; they do not advance byte_cnt.
// TESTING
//  1. FRAME_LEN=16, 16 beats cnt_in=4, sum_ready=1 -> one result, sum_total=64,
//     sum_bytes=16, balanced=1, sum_valid high for 1 cycle, 1 cycle after beat 16.
//  2. Beats 8,8,3 with frame_last on the 3rd -> sum_total=19, sum_bytes=3, balanced=0.
//  3. Frame closes with sum_ready=0 for 5 cycles -> cnt_ready=0, outputs stable;
//     sum_ready=1 with cnt_valid=1, cnt_in=2 -> result drained, new frame acc=2.
//  4. cnt_in=4'hF mid-frame -> counted as 8, err_range=1 and still 1 after later frames.
//  5. Reset asserted after 7 beats -> sum_valid=0, acc=0; a following full frame of
//     cnt_in=1 gives sum_total=16.
//  6. FRAME_LEN=1, continuous beats, sum_ready toggling -> one result per beat,
//     none dropped, order preserved.

Source files
------------

// File: rtl/ones_frame_accumulator.sv
// Sums per-byte ones counts over a frame and presents the total, byte count and
// balanced flag on a valid/ready output, with upstream backpressure via cnt_ready.
module ones_frame_accumulator #(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_valid,
    input  logic [3:0]       cnt_in,
    input  logic             frame_last,
    output logic             cnt_ready,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [SUM_W-1:0] sum_total,
    output logic [7:0]       sum_bytes,
    output logic             balanced,
    output logic             err_range
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int CMP_W = (SUM_W > 10) ? SUM_W : 10;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] total_q, total_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       bytes_q, bytes_d;
    logic             valid_q, valid_d;
    logic             bal_q, bal_d;
    logic             err_q, err_d;

    logic [3:0]       cnt_sat;
    logic             accept;
    logic             close;
    logic [SUM_W-1:0] acc_next;
    logic [7:0]       cnt_next;
    logic [CMP_W-1:0] tot_ext;
    logic [CMP_W-1:0] quad_ext;

    always_comb begin
        cnt_sat   = (cnt_in > 4'd8) ? 4'd8 : cnt_in;
        cnt_ready = (state_q == ACCUM) || sum_ready;
        accept    = cnt_valid && cnt_ready;
        acc_next  = acc_q + SUM_W'(cnt_sat);
        cnt_next  = cnt_q + 8'd1;
        close     = accept && ((cnt_next == 8'(FRAME_LEN)) || frame_last);
        tot_ext   = CMP_W'(acc_next);
        quad_ext  = CMP_W'({cnt_next, 2'b00});

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        bytes_d = bytes_q;
        valid_d = valid_q;
        bal_d   = bal_q;
        err_d   = err_q;

        if (state_q == HOLD && sum_ready) begin
            valid_d = 1'b0;
            state_d = ACCUM;
        end

        // acc/cnt are already zero while holding, so a beat accepted on the draining
        // cycle naturally becomes the first beat of the next frame.
        if (accept) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            if (cnt_in > 4'd8) begin
                err_d = 1'b1;
            end
        end

        if (close) begin
            total_d = acc_next;
            bytes_d = cnt_next;
            bal_d   = (tot_ext == quad_ext);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
            bal_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
            bal_q   <= bal_d;
            err_q   <= err_d;
        end
    end

    assign sum_valid = valid_q;
    assign sum_total = total_q;
    assign sum_bytes = bytes_q;
    assign balanced  = bal_q;
    assign err_range = err_q;

endmodule
